// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a byte FIFO and a programmable baud divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0100,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic        hit,
  output logic [31:0] memreaddata,
  output logic        txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [4:0]      count;
  logic            overflow;
  logic [15:0]     div, cnt;
  logic [2:0]      bitn;
  logic [7:0]      sh;
  logic            we, push, pop, full, empty, bit_end, unused_bits;
  logic [31:0]     status;
  always_comb begin
    hit         = memaddr[31:4] == BASE_ADDR[31:4];
    we          = hit & memwrite;
    full        = count == 5'(FIFO_DEPTH);
    empty       = count == 5'd0;
    bit_end     = cnt == 16'd0;
    pop         = !empty && (state == IDLE || (state == STOP && bit_end));
    push        = we && memaddr[3:0] == 4'h0 && (!full || pop);
    status      = {23'b0, count, overflow, empty, full, state != IDLE};
    memreaddata = !hit ? 32'b0 : memaddr[3:0] == 4'h4 ? status :
                  memaddr[3:0] == 4'h8 ? {16'b0, div} : 32'b0;
    unused_bits = ^memwritedata[31:16];
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= memwritedata[7:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      wp       <= '0;
      rp       <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      div      <= DIV_RESET;
      cnt      <= 16'd0;
      bitn     <= 3'd0;
      sh       <= 8'd0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + 5'(push) - 5'(pop);
      if (we && memaddr[3:0] == 4'h0 && full && !pop) overflow <= 1'b1;
      else if (we && memaddr[3:0] == 4'h4 && memwritedata[3]) overflow <= 1'b0;
      if (we && memaddr[3:0] == 4'h8) div <= memwritedata[15:0] == 16'd0 ? 16'd1 : memwritedata[15:0];
      // cnt reloads from div only at bit boundaries, so a new divisor waits for the next bit
      case (state)
        IDLE: if (pop) begin
          sh    <= mem[rp];
          txd   <= 1'b0;
          cnt   <= div - 16'd1;
          state <= START;
        end
        START: if (bit_end) begin
          txd   <= sh[0];
          bitn  <= 3'd0;
          cnt   <= div - 16'd1;
          state <= DATA;
        end else cnt <= cnt - 16'd1;
        DATA: if (bit_end) begin
          cnt <= div - 16'd1;
          if (bitn == 3'd7) begin
            txd   <= 1'b1;
            state <= STOP;
          end else begin
            txd  <= sh[1];
            sh   <= sh >> 1;
            bitn <= bitn + 3'd1;
          end
        end else cnt <= cnt - 16'd1;
        STOP: if (bit_end) begin
          sh    <= mem[rp];
          txd   <= !pop;
          cnt   <= pop ? div - 16'd1 : 16'd0;
          state <= pop ? START : IDLE;
        end else cnt <= cnt - 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized bench comparing the UART against a FIFO/line-level queue model.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF0100;
  localparam int DEPTH = 8;
  logic clk = 1'b0, reset, memwrite, hit, txd;
  logic [31:0] memaddr, memwritedata, memreaddata;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  bit line[$];
  int rem, div;
  bit ovf;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .hit(hit), .memreaddata(memreaddata), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    line.delete();
    rem = 0;
    ovf = 0;
    div = 434;
  endfunction

  function automatic logic [31:0] m_rd(logic [31:0] a);
    logic [31:0] s = 0;
    if (a[31:4] != BASE[31:4]) return 0;
    if (a[3:0] == 4'h8) return div;
    if (a[3:0] != 4'h4) return 0;
    s[8:4] = 5'(q.size());
    s[3] = ovf;
    s[2] = q.size() == 0;
    s[1] = q.size() == DEPTH;
    s[0] = line.size() != 0;
    return s;
  endfunction

  function automatic bit m_txd();
    return line.size() != 0 ? line[0] : 1'b1;
  endfunction

  // Line is a queue of pending levels; each level holds for the divisor seen when it starts.
  function automatic void m_step(bit we, logic [31:0] a, logic [31:0] d);
    logic [7:0] b;
    if (line.size() != 0) begin
      if (rem == 1) begin
        void'(line.pop_front());
        rem = div;
      end else rem--;
    end
    if (line.size() == 0 && q.size() != 0) begin
      b = q.pop_front();
      line.push_back(1'b0);
      for (int i = 0; i < 8; i++) line.push_back(b[i]);
      line.push_back(1'b1);
      rem = div;
    end
    if (we && a[31:4] == BASE[31:4]) begin
      if (a[3:0] == 4'h0) begin
        if (q.size() < DEPTH) q.push_back(d[7:0]);
        else ovf = 1;
      end else if (a[3:0] == 4'h4 && d[3]) ovf = 0;
      else if (a[3:0] == 4'h8) div = d[15:0] == 0 ? 1 : int'(d[15:0]);
    end
  endfunction

  task automatic cycle(bit we, logic [31:0] a, logic [31:0] d);
    memwrite = we;
    memaddr = a;
    memwritedata = d;
    #1;
    check("hit", hit, a[31:4] == BASE[31:4]);
    check("rdata", memreaddata, m_rd(a));
    @(posedge clk);
    m_step(we, a, d);
    @(negedge clk);
    check("txd", txd, m_txd());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, BASE + 32'(4 * (i % 3)), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1;
    #1 check("rst_txd", txd, 1);
    m_reset();
    memwrite = 0;
    memaddr = BASE + 4;
    #1 check("rst_status", memreaddata, 32'h4);
    memaddr = BASE + 8;
    #1 check("rst_div", memreaddata, 32'd434);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int r;
    reset = 1;
    memwrite = 0;
    memaddr = 0;
    memwritedata = 0;
    m_reset();
    @(negedge clk);
    check("init_txd", txd, 1);
    memaddr = BASE + 4;
    #1 check("init_status", memreaddata, 32'h4);
    @(negedge clk);
    reset = 0;
    // div=4, single 0x55 frame
    cycle(1, BASE + 8, 4);
    cycle(1, BASE, 32'h55);
    idle(45);
    // div=2, back-to-back frames
    cycle(1, BASE + 8, 2);
    cycle(1, BASE, 32'hA5);
    cycle(1, BASE, 32'h3C);
    idle(45);
    // divisor 0 stored as 1
    cycle(1, BASE + 8, 0);
    cycle(1, BASE, 32'h0F);
    idle(15);
    // divisor change mid-DATA
    cycle(1, BASE + 8, 8);
    cycle(1, BASE, 32'h96);
    idle(24);
    cycle(1, BASE + 8, 2);
    idle(70);
    // overflow at div=100
    cycle(1, BASE + 8, 100);
    for (int i = 0; i < 10; i++) cycle(1, BASE, 32'(8'h30 + i));
    idle(3);
    cycle(1, BASE + 4, 8);
    idle(3);
    do_reset();
    // reset during a div=4 frame while txd is low
    cycle(1, BASE + 8, 4);
    cycle(1, BASE, 32'h00);
    idle(14);
    do_reset();
    // outside the window and the unused offset
    cycle(1, BASE + 16, 32'h41);
    cycle(1, BASE - 4, 32'h42);
    cycle(1, BASE + 12, 32'hFFFF);
    cycle(0, BASE + 12, 0);
    idle(3);
    cycle(1, BASE + 8, 3);
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 999);
      if (r < 2) do_reset();
      else if (r < 90) cycle(1, BASE, $urandom);
      else if (r < 110) cycle(1, BASE + 8, $urandom_range(0, 4));
      else if (r < 130) cycle(1, BASE + 4, $urandom);
      else if (r < 160) cycle(1, BASE + 32'($urandom_range(1, 3) * 16), $urandom);
      else cycle(0, BASE + 32'(4 * $urandom_range(0, 3)), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF0100, 16-byte-aligned base of the register window.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two, 2..16.
REQ-003 Parameter DIV_RESET, default 16'd434, baud divisor loaded at reset.
REQ-004 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port memwrite, input, 1, store strobe from the CPU data port.
REQ-007 Port memaddr, input, 32, byte address from the CPU data port.
REQ-008 Port memwritedata, input, 32, store data.
REQ-009 Port hit, output, 1, high when memaddr[31:4] == BASE_ADDR[31:4]; combinational; used by the system read mux.
REQ-010 Port memreaddata, output, 32, register read data; combinational; 0 when hit is low.
REQ-011 Port txd, output, 1, serial line; idle high.

Function
REQ-012 Register map (offset = memaddr[3:0]): 0x0 TXDATA (write only); 0x4 STATUS; 0x8 BAUDDIV; all other offsets read 0, ignore writes.
REQ-013 Write takes effect when hit & memwrite at the rising edge; reads are combinational, no side effects.
REQ-014 TXDATA write pushes memwritedata[7:0] into FIFO; reads of TXDATA return 0.
REQ-015 Push when FIFO full and no pop on the same edge: byte dropped, overflow sticky bit set.
REQ-016 Push and pop on the same edge: both happen; count unchanged; a push to a full FIFO with a simultaneous pop is accepted.
REQ-017 STATUS read = {23'b0, count[4:0], overflow, empty, full, busy} (bits 8:4 count, 3 overflow, 2 empty, 1 full, 0 busy).
REQ-018 STATUS write with memwritedata[3]=1 clears overflow; if the same edge also sets it (impossible, different offsets), n/a; other bits read-only.
REQ-019 BAUDDIV read = {16'b0, div}; write loads memwritedata[15:0]; value 0 stored as 1.
REQ-020 Each serial bit lasts exactly div clock cycles; a new div value applies from the next bit boundary; the current bit completes with the old value.
REQ-021 Frame: start bit 0, data bits 0..7 LSB first, one stop bit 1; 10*div cycles per frame.
REQ-022 FSM states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-023 IDLE: txd=1; on an edge with FIFO non-empty -> pop head into shifter, enter START; txd=0 from that edge.
REQ-024 START -> DATA after div cycles; DATA sends bit index 0..7 (3-bit counter), -> STOP after bit 7's div cycles.
REQ-025 STOP, last cycle: FIFO non-empty -> pop, go to START (no idle gap between frames); else -> IDLE.
REQ-026 Latency: write of TXDATA sampled at edge k into an empty FIFO with FSM IDLE -> pop and txd falls at edge k+1.
REQ-027 FIFO: circular, read/write pointers wrap modulo FIFO_DEPTH; full = count==FIFO_DEPTH, empty = count==0.
REQ-028 txd driven from a flop (glitch-free).

Reset
REQ-029 Reset asserted: immediately state=IDLE, txd=1, FIFO empty (pointers, count 0), overflow=0, div=DIV_RESET, bit/baud counters 0; a frame in progress is abandoned.
REQ-030 First push accepted at the first rising edge after reset deassertion.

Verification
REQ-031 Reset, write BAUDDIV=4, write TXDATA=0x55 -> txd 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4; busy=0 after 40 cycles.
REQ-032 div=2, write 0xA5 then 0x3C back-to-back -> 40 cycles of continuous framing, second start bit directly after first stop bit, no idle cycle.
REQ-033 div=100, push 9 bytes (FIFO_DEPTH=8) while the first is transmitting -> first pops at once, remaining 8 fill FIFO, full=1, overflow=0; 10th push -> dropped, overflow=1; STATUS write 0x8 -> overflow=0.
REQ-034 Reset asserted at cycle 15 of a div=4 frame -> txd=1 same cycle without waiting for clk, STATUS reads 0x4 (empty), BAUDDIV reads 434.
REQ-035 BAUDDIV write 0 -> reads 1, bits last 1 cycle; BAUDDIV changed 8->2 mid-DATA -> current bit 8 cycles, next bits 2.
REQ-036 memaddr outside window (e.g., BASE_ADDR+0x10) with memwrite=1 -> hit=0, memreaddata=0, no state change; offset 0xC reads 0.
